// File: rtl/spram_ctrl_pkg.sv
// Shared types and helpers for the cascaded 32-bit SPRAM controller.
package spram_ctrl_pkg;

    // Power/availability state of the SPRAM pair.
    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_STANDBY = 2'd1,
        ST_SLEEP   = 2'd2,
        ST_WAKE    = 2'd3
    } pwr_state_e;

    // Edges from request accept to the cycle in which rsp_valid is high.
    localparam int RSP_LATENCY = 2;

    // Byte enables to nibble write masks: {hi[3:0], lo[3:0]}.
    // Each byte enable drives the two nibble bits covering that byte.
    function automatic logic [7:0] be_to_nibble_mask(input logic [3:0] be);
        return {be[3], be[3], be[2], be[2], be[1], be[1], be[0], be[0]};
    endfunction

endpackage

// File: rtl/spram_power_seq.sv
// Idle/standby/wake sequencing for the SPRAM pair.
// Optional sleep support is compiled in with `define SPRAM_SLEEP_EN.
module spram_power_seq
    import spram_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES       = 16,
    parameter int WAKE_CYCLES       = 2,
    parameter int SLEEP_CYCLES      = 256,
    parameter int SLEEP_WAKE_CYCLES = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       req_valid_i,
    input  logic       accept_i,
    input  logic       rd_busy_i,
    output pwr_state_e state_o,
    output logic       mem_standby_o,
    output logic       mem_sleep_o
);

    // One counter width wide enough for every limit keeps the arithmetic uniform.
    localparam int MAX_A   = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int MAX_B   = (SLEEP_CYCLES > SLEEP_WAKE_CYCLES) ? SLEEP_CYCLES : SLEEP_WAKE_CYCLES;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] IDLE_LIM   = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] WAKE_LIM   = CNT_W'(WAKE_CYCLES);
    localparam bit               STANDBY_EN = (IDLE_CYCLES != 0);
`ifdef SPRAM_SLEEP_EN
    localparam logic [CNT_W-1:0] SLEEP_LIM      = CNT_W'(SLEEP_CYCLES);
    localparam logic [CNT_W-1:0] SLEEP_WAKE_LIM = CNT_W'(SLEEP_WAKE_CYCLES);
`endif

    pwr_state_e       state_q, state_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic [CNT_W-1:0] wake_q, wake_d;
    logic [CNT_W-1:0] wake_lim_q, wake_lim_d;
`ifdef SPRAM_SLEEP_EN
    logic [CNT_W-1:0] sleep_q, sleep_d;
`endif

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_ACTIVE;
            idle_q     <= '0;
            wake_q     <= '0;
            wake_lim_q <= '0;
`ifdef SPRAM_SLEEP_EN
            sleep_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idle_q     <= idle_d;
            wake_q     <= wake_d;
            wake_lim_q <= wake_lim_d;
`ifdef SPRAM_SLEEP_EN
            sleep_q    <= sleep_d;
`endif
        end
    end

    // Next state; each counter only runs in the state that owns it.
    always_comb begin
        state_d    = state_q;
        idle_d     = '0;
        wake_d     = '0;
        wake_lim_d = wake_lim_q;
`ifdef SPRAM_SLEEP_EN
        sleep_d    = '0;
`endif
        case (state_q)
            ST_ACTIVE: begin
                if (accept_i || rd_busy_i) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_LIM) begin
                    idle_d = idle_q;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
                // Enter standby on the edge the idle count reaches its limit.
                if (STANDBY_EN && !req_valid_i && (idle_d == IDLE_LIM)) begin
                    state_d = ST_STANDBY;
                    idle_d  = '0;
                end
            end
            ST_STANDBY: begin
                if (req_valid_i) begin
                    state_d    = (WAKE_LIM == '0) ? ST_ACTIVE : ST_WAKE;
                    wake_lim_d = WAKE_LIM;
                end
`ifdef SPRAM_SLEEP_EN
                else if ((sleep_q + 1'b1) == SLEEP_LIM) begin
                    state_d = ST_SLEEP;
                end else begin
                    sleep_d = sleep_q + 1'b1;
                end
`endif
            end
`ifdef SPRAM_SLEEP_EN
            ST_SLEEP: begin
                if (req_valid_i) begin
                    state_d    = (SLEEP_WAKE_LIM == '0) ? ST_ACTIVE : ST_WAKE;
                    wake_lim_d = SLEEP_WAKE_LIM;
                end
            end
`endif
            ST_WAKE: begin
                if ((wake_q + 1'b1) == wake_lim_q) begin
                    state_d = ST_ACTIVE;
                end else begin
                    wake_d = wake_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
    end

    // Power pins follow the registered state directly.
    always_comb begin
        state_o       = state_q;
        mem_standby_o = (state_q == ST_STANDBY);
`ifdef SPRAM_SLEEP_EN
        mem_sleep_o   = (state_q == ST_SLEEP);
`else
        mem_sleep_o   = 1'b0;
`endif
    end

endmodule

// File: rtl/spram_ctrl.sv
// Controller for a 32-bit data memory built from two 16-bit SPRAM macros.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready never depends on req_valid, and the initiator holds req_* stable
// while req_valid=1 and req_ready=0. Reads return rsp_valid for one cycle,
// in order, RSP_LATENCY edges after the accept; writes return nothing.
// Optional sleep support is compiled in with `define SPRAM_SLEEP_EN.
module spram_ctrl
    import spram_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES       = 16,
    parameter int WAKE_CYCLES       = 2,
    parameter int SLEEP_CYCLES      = 256,
    parameter int SLEEP_WAKE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [13:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [13:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_maskwren_hi,
    output logic [3:0]  mem_maskwren_lo,
    output logic        mem_wren,
    output logic        mem_chipsel,
    output logic        mem_standby,
    output logic        mem_sleep,
    output logic        mem_poweroff,
    input  logic [31:0] mem_rdata
);

    pwr_state_e pwr_state;
    logic       accept;

    logic [13:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [7:0]             mask_q, mask_d;
    logic                   wren_q, wren_d;
    logic                   chipsel_q, chipsel_d;
    logic [RSP_LATENCY-1:0] rd_pipe_q, rd_pipe_d;

    spram_power_seq #(
        .IDLE_CYCLES       (IDLE_CYCLES),
        .WAKE_CYCLES       (WAKE_CYCLES),
        .SLEEP_CYCLES      (SLEEP_CYCLES),
        .SLEEP_WAKE_CYCLES (SLEEP_WAKE_CYCLES)
    ) u_power_seq (
        .clk_i         (clk),
        .reset_i       (reset),
        .req_valid_i   (req_valid),
        .accept_i      (accept),
        .rd_busy_i     (|rd_pipe_q),
        .state_o       (pwr_state),
        .mem_standby_o (mem_standby),
        .mem_sleep_o   (mem_sleep)
    );

    // Handshake: ready only while the macros are awake and out of reset.
    always_comb begin
        req_ready = (pwr_state == ST_ACTIVE) && !reset;
        accept    = req_valid && req_ready;
    end

    // Next macro-pin values; address and data hold when nothing is accepted.
    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mask_d    = 8'h00;
        wren_d    = 1'b0;
        chipsel_d = 1'b0;
        if (accept) begin
            addr_d    = req_addr;
            wdata_d   = req_wdata;
            chipsel_d = 1'b1;
            // A write with no byte enabled is a select-only no-op.
            wren_d    = req_we && (req_be != 4'h0);
            mask_d    = req_we ? be_to_nibble_mask(req_be) : 8'h00;
        end
        rd_pipe_d = {rd_pipe_q[RSP_LATENCY-2:0], accept && !req_we};
    end

    // Datapath and read-tracking registers; reset cancels in-flight reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            wren_q    <= 1'b0;
            chipsel_q <= 1'b0;
            rd_pipe_q <= '0;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            wren_q    <= wren_d;
            chipsel_q <= chipsel_d;
            rd_pipe_q <= rd_pipe_d;
        end
    end

    // Pin mapping and read-data pass-through (zero outside a response).
    always_comb begin
        mem_addr        = addr_q;
        mem_wdata       = wdata_q;
        mem_maskwren_hi = mask_q[7:4];
        mem_maskwren_lo = mask_q[3:0];
        mem_wren        = wren_q;
        mem_chipsel     = chipsel_q;
        mem_poweroff    = 1'b1;
        rsp_valid       = rd_pipe_q[RSP_LATENCY-1];
        rsp_rdata       = rsp_valid ? mem_rdata : 32'h0;
    end

endmodule
